// File: rtl/spi_bus_monitor.sv
// Passive SPI bus monitor: decodes MOSI/MISO into parallel words in any CKP/CPH mode.
// Optional truncated-word error reporting is enabled by defining SPI_MON_ERR_EN.
module spi_bus_monitor #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CKP,
    input  logic              CPH,
    input  logic              CS,
    input  logic              SCK,
    input  logic              MOSI,
    input  logic              MISO,
    output logic [WORD_W-1:0] mosi_word,
    output logic [WORD_W-1:0] miso_word,
    output logic              word_valid,
    output logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              frame_err,
    output logic [CNT_W-1:0]  err_cnt
);

    // state  | meaning
    // RESYNC | after reset; wait for CS high before trusting the bus
    // IDLE   | CS high; wait for CS falling edge to start a frame
    // SHIFT  | CS low; shift one bit per sample edge, emit a word every WORD_W bits
    typedef enum logic [1:0] {
        ST_RESYNC,
        ST_IDLE,
        ST_SHIFT
    } state_t;

    localparam int BIT_W = $clog2(WORD_W);

    state_t state, state_nx;

    logic [2:0]        cs_sync, sck_sync;
    logic [1:0]        mosi_sync, miso_sync;
    logic              ckp_l, cph_l;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] mosi_sr, miso_sr;
    logic [WORD_W-1:0] mosi_next, miso_next;
    logic              cs_rise, cs_fall, sck_rise, sck_fall, sample;
    logic              start, shift_en, word_done;

    // CS syncs reset low so RESYNC only leaves on a genuinely high CS
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_sync   <= '0;
            sck_sync  <= '0;
            mosi_sync <= '0;
            miso_sync <= '0;
        end else begin
            cs_sync   <= {cs_sync[1:0], CS};
            sck_sync  <= {sck_sync[1:0], SCK};
            mosi_sync <= {mosi_sync[0], MOSI};
            miso_sync <= {miso_sync[0], MISO};
        end
    end

    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign sck_rise  = sck_sync[1] & ~sck_sync[2];
    assign sck_fall  = ~sck_sync[1] & sck_sync[2];
    assign sample    = (ckp_l == cph_l) ? sck_rise : sck_fall;
    assign mosi_next = {mosi_sr[WORD_W-2:0], mosi_sync[1]};
    assign miso_next = {miso_sr[WORD_W-2:0], miso_sync[1]};
    assign busy      = (state == ST_SHIFT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RESYNC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        start     = 1'b0;
        shift_en  = 1'b0;
        word_done = 1'b0;
        case (state)
            ST_RESYNC: begin
                if (cs_sync[1]) state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    state_nx = ST_SHIFT;
                    start    = 1'b1;
                end
            end
            ST_SHIFT: begin
                // a CS edge in the same cycle as a sample edge drops the sample
                if (cs_rise) begin
                    state_nx = ST_IDLE;
                end else if (sample) begin
                    shift_en  = 1'b1;
                    word_done = (bit_cnt == BIT_W'(WORD_W - 1));
                end
            end
            default: state_nx = ST_RESYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ckp_l      <= 1'b0;
            cph_l      <= 1'b0;
            bit_cnt    <= '0;
            mosi_sr    <= '0;
            miso_sr    <= '0;
            mosi_word  <= '0;
            miso_word  <= '0;
            word_valid <= 1'b0;
            word_count <= '0;
        end else begin
            word_valid <= word_done;
            if (start) begin
                ckp_l      <= CKP;
                cph_l      <= CPH;
                bit_cnt    <= '0;
                word_count <= '0;
            end
            if (shift_en) begin
                mosi_sr <= mosi_next;
                miso_sr <= miso_next;
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            end
            if (word_done) begin
                mosi_word <= mosi_next;
                miso_word <= miso_next;
                if (word_count != '1) word_count <= word_count + 1'b1;
            end
        end
    end

`ifdef SPI_MON_ERR_EN
    logic cut_word;
    assign cut_word = (state == ST_SHIFT) && cs_rise && (bit_cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            frame_err <= cut_word;
            if (cut_word && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    assign frame_err = 1'b0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_spi_bus_monitor.sv
// Self-checking bench for spi_bus_monitor: pin-level SPI master plus a bit-stream model
// that predicts every decoded word, its frame count and every truncated-word error.
module tb_spi_bus_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        CKP = 1'b0, CPH = 1'b0, CS = 1'b1, SCK = 1'b0, MOSI = 1'b0, MISO = 1'b0;
    logic [15:0] mosi_word, miso_word;
    logic        word_valid, busy, frame_err;
    logic [7:0]  word_count, err_cnt;

`ifdef SPI_MON_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    spi_bus_monitor dut (
        .clk(clk), .rst(rst), .CKP(CKP), .CPH(CPH), .CS(CS), .SCK(SCK),
        .MOSI(MOSI), .MISO(MISO), .mosi_word(mosi_word), .miso_word(miso_word),
        .word_valid(word_valid), .word_count(word_count), .busy(busy),
        .frame_err(frame_err), .err_cnt(err_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // model state: words expected in order, plus what the outputs must hold between words
    logic [15:0] exp_mosi_q[$];
    logic [15:0] exp_miso_q[$];
    int          exp_cnt_q[$];
    logic [15:0] last_mosi = '0, last_miso = '0;
    logic [15:0] sr_mo = '0, sr_mi = '0;
    bit          m_ckp = 0, m_cph = 0, m_active = 0;
    int          samp_cnt = 0, frame_words = 0, mdl_err = 0, err_pending = 0;
    bit          mon_en = 0, lat_chk = 0;
    bit          drv_ckp = 0, drv_cph = 0;
    int          cyc = 0, prev_v = 0, last_v = 0;

    always @(negedge clk) begin
        logic [15:0] em, ei;
        int          ec;
        cyc++;
        if (mon_en && rst) begin
            if (word_valid) begin
                prev_v = last_v;
                last_v = cyc;
                if (exp_mosi_q.size() == 0) begin
                    chk("spurious_valid", word_valid, 0);
                end else begin
                    em = exp_mosi_q.pop_front();
                    ei = exp_miso_q.pop_front();
                    ec = exp_cnt_q.pop_front();
                    chk("mosi_word", mosi_word, em);
                    chk("miso_word", miso_word, ei);
                    chk("word_count", word_count, ec);
                    last_mosi = em;
                    last_miso = ei;
                end
            end else begin
                chk("mosi_hold", mosi_word, last_mosi);
                chk("miso_hold", miso_word, last_miso);
            end
            if (frame_err) begin
                if (err_pending == 0) chk("spurious_frame_err", frame_err, 0);
                else err_pending--;
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // every SCK pin change goes through here so the model sees the edge and data levels
    task automatic sck_set(input logic lvl);
        if (m_active && (lvl != SCK)) begin
            if ((m_ckp == m_cph) ? lvl : !lvl) begin
                sr_mo = {sr_mo[14:0], MOSI};
                sr_mi = {sr_mi[14:0], MISO};
                samp_cnt++;
                if (samp_cnt % 16 == 0) begin
                    frame_words = (frame_words < 255) ? frame_words + 1 : 255;
                    exp_mosi_q.push_back(sr_mo);
                    exp_miso_q.push_back(sr_mi);
                    exp_cnt_q.push_back(frame_words);
                end
            end
        end
        SCK = lvl;
    endtask

    task automatic begin_frame(input bit pckp, input bit pcph, input bit dckp, input bit dcph);
        drv_ckp = dckp;
        drv_cph = dcph;
        CKP  = pckp;
        CPH  = pcph;
        SCK  = dckp;
        MOSI = 1'b0;
        MISO = 1'b0;
        wait_clk(4);
        m_ckp = pckp;
        m_cph = pcph;
        m_active = 1;
        samp_cnt = 0;
        frame_words = 0;
        sr_mo = '0;
        sr_mi = '0;
        CS = 1'b0;
        wait_clk(4);
        chk("busy_in_frame", busy, 1);
    endtask

    // sends the top nbits of mo/mi, MSB first, with the master timing of drv_ckp/drv_cph
    task automatic send_bits(input logic [15:0] mo, input logic [15:0] mi, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (!drv_cph) begin
                MOSI = mo[15-i];
                MISO = mi[15-i];
            end
            wait_clk(2);
            sck_set(!drv_ckp);
            if (lat_chk && (i == nbits - 1)) begin
                @(posedge clk);
                @(posedge clk);
                #1 chk("valid_not_before_3clk", word_valid, 0);
                @(posedge clk);
                #1 chk("valid_at_3clk", word_valid, 1);
                @(negedge clk);
            end
            wait_clk(2);
            if (drv_cph) begin
                MOSI = mo[15-i];
                MISO = mi[15-i];
            end
            wait_clk(2);
            sck_set(drv_ckp);
            wait_clk(2);
        end
    endtask

    task automatic end_frame();
        if (m_active && (samp_cnt % 16 != 0) && ERR_EN) begin
            err_pending++;
            if (mdl_err < 255) mdl_err++;
        end
        m_active = 0;
        CS = 1'b1;
        wait_clk(8);
        chk("words_drained", exp_mosi_q.size(), 0);
        chk("frame_err_pulses", err_pending, 0);
        chk("err_cnt", err_cnt, mdl_err);
        chk("busy_after_frame", busy, 0);
        chk("word_count_end", word_count, frame_words);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_mosi_word"}, mosi_word, 0);
        chk({tag, "_miso_word"}, miso_word, 0);
        chk({tag, "_word_valid"}, word_valid, 0);
        chk({tag, "_word_count"}, word_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2 rst = 1'b0;
        exp_mosi_q.delete();
        exp_miso_q.delete();
        exp_cnt_q.delete();
        last_mosi = '0;
        last_miso = '0;
        mdl_err = 0;
        err_pending = 0;
        m_active = 0;
        frame_words = 0;
        #3 check_reset_values("midframe_rst");
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    bit mode_ckp[3] = '{1'b0, 1'b1, 1'b0};
    bit mode_cph[3] = '{1'b0, 1'b1, 1'b1};

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("por");
        @(posedge clk);
        #2 rst = 1'b1;
        wait_clk(4);
        mon_en = 1;

        // mode 10 with bit-latency pin
        lat_chk = 1;
        begin_frame(1, 0, 1, 0);
        send_bits(16'h0309, 16'h0807, 16);
        lat_chk = 0;
        end_frame();
        chk("m10_mosi", mosi_word, 16'h0309);
        chk("m10_miso", miso_word, 16'h0807);
        chk("m10_count", word_count, 1);
        chk("m10_err_cnt", err_cnt, 0);

        // modes 00, 11, 01
        for (int k = 0; k < 3; k++) begin
            begin_frame(mode_ckp[k], mode_cph[k], mode_ckp[k], mode_cph[k]);
            send_bits(16'h0309, 16'h0807, 16);
            end_frame();
            chk("mode_mosi", mosi_word, 16'h0309);
            chk("mode_miso", miso_word, 16'h0807);
        end

        // wrong mode: master drives CPH=1 timing, monitor told CPH=0 -> one-bit slip
        begin_frame(0, 0, 0, 1);
        send_bits(16'h0309, 16'h0807, 16);
        end_frame();
        chk("neg_mosi_differs", (mosi_word != 16'h0309), 1);
        chk("neg_mosi", mosi_word, 16'h0184);
        chk("neg_miso", miso_word, 16'h0403);

        // two-word frame
        begin_frame(0, 0, 0, 0);
        send_bits(16'h0309, 16'h0807, 16);
        send_bits(16'hA5C3, 16'h5A3C, 16);
        end_frame();
        chk("two_mosi", mosi_word, 16'hA5C3);
        chk("two_miso", miso_word, 16'h5A3C);
        chk("two_count", word_count, 2);
        chk("two_valid_gap_ge32", ((last_v - prev_v) >= 32), 1);

        // truncated word: 9 bits then CS high
        begin_frame(0, 0, 0, 0);
        send_bits(16'h1234, 16'hFEDC, 9);
        end_frame();
        chk("trunc_mosi_held", mosi_word, 16'hA5C3);
        chk("trunc_miso_held", miso_word, 16'h5A3C);
        chk("trunc_count", word_count, 0);
        chk("trunc_err_cnt", err_cnt, ERR_EN ? 1 : 0);

        // reset mid-frame, remainder of frame must be ignored
        begin_frame(0, 0, 0, 0);
        send_bits(16'hFFFF, 16'hFFFF, 5);
        reset_pulse();
        send_bits(16'hFFFF, 16'hFFFF, 16);
        end_frame();
        chk("abort_mosi", mosi_word, 16'h0000);
        begin_frame(0, 0, 0, 0);
        send_bits(16'h0309, 16'h0807, 16);
        end_frame();
        chk("after_rst_mosi", mosi_word, 16'h0309);
        chk("after_rst_count", word_count, 1);
        chk("after_rst_err_cnt", err_cnt, 0);

        // mode pins toggled mid-frame have no effect
        begin_frame(0, 0, 0, 0);
        send_bits(16'h0309, 16'h0807, 4);
        CKP = 1'b1;
        CPH = 1'b1;
        send_bits(16'h3090, 16'h8070, 12);
        end_frame();
        chk("toggle_mosi", mosi_word, 16'h0309);
        chk("toggle_miso", miso_word, 16'h0807);
        chk("toggle_count", word_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
